// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with one-entry IF/ID slot, HALT stop and redirect flush
// Optional FETCH_PERF_CNT_EN adds fetch_count/stall_count outputs.
module fetch_unit #(
  parameter int PC_W      = 32,
  parameter int MEM_DEPTH = 32,
  parameter int INSTR_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PC_W-1:0]    start_pc,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instruction,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic               if_halt,
`ifdef FETCH_PERF_CNT_EN
  output logic               halted,
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_count
`else
  output logic               halted
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HALTED
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [PC_W-1:0]      r_pc;
  logic                 r_if_valid;
  logic [INSTR_W-1:0]   r_if_instr;
  logic [PC_W-1:0]      r_if_pc;
  logic                 r_if_halt;

  logic                 w_slot_free;
  logic                 w_is_halt;
  logic                 w_redirect;
  logic                 w_flush_slot;
  logic                 w_capture;
  logic [PC_W-1:0]      w_pc_inc;

  assign w_slot_free  = !r_if_valid || if_ready;
  assign w_is_halt    = (instruction == '0);
  // Redirects only mean something once fetching has begun.
  assign w_redirect   = redirect_valid && (r_state != S_IDLE);
  assign w_flush_slot = w_redirect || (start && (r_state == S_FETCH));
  assign w_capture    = (r_state == S_FETCH) && !w_redirect && !start && w_slot_free;
  assign w_pc_inc     = (r_pc == PC_W'(MEM_DEPTH - 1)) ? '0 : r_pc + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (w_redirect || start) begin
      w_next_state = S_FETCH;
    end else if (w_capture && w_is_halt) begin
      w_next_state = S_HALTED;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= '0;
      r_if_valid <= 1'b0;
      r_if_instr <= '0;
      r_if_pc    <= '0;
      r_if_halt  <= 1'b0;
    end else begin
      if (w_redirect) begin
        r_pc <= redirect_pc;
      end else if (start) begin
        r_pc <= start_pc;
      end else if (w_capture && !w_is_halt) begin
        r_pc <= w_pc_inc;
      end

      // A captured HALT leaves pc parked on its own index.
      if (w_flush_slot) begin
        r_if_valid <= 1'b0;
        r_if_halt  <= 1'b0;
      end else if (w_capture) begin
        r_if_valid <= 1'b1;
        r_if_instr <= instruction;
        r_if_pc    <= r_pc;
        r_if_halt  <= w_is_halt;
      end else if (r_if_valid && if_ready) begin
        r_if_valid <= 1'b0;
      end
    end
  end

  assign pc       = r_pc;
  assign if_valid = r_if_valid;
  assign if_instr = r_if_instr;
  assign if_pc    = r_if_pc;
  assign if_halt  = r_if_halt;
  assign halted   = (r_state == S_HALTED);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_stall_count;
  logic        w_stall;

  assign w_stall = (r_state == S_FETCH) && !w_redirect && !start && !w_slot_free;

  always_ff @(posedge clk) begin
    if (reset || start) begin
      r_fetch_count <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_capture && (r_fetch_count != 32'hFFFF_FFFF)) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (w_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

  assign fetch_count = r_fetch_count;
  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized checks of fetch_unit against a word-stream model
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] start_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_halt;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [32];

  always #5 clk = ~clk;

  fetch_unit #(.PC_W(32), .MEM_DEPTH(32), .INSTR_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .start_pc       (start_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc),
    .instruction    (instruction),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_halt        (if_halt),
`ifdef FETCH_PERF_CNT_EN
    .halted         (halted),
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
`else
    .halted         (halted)
`endif
  );

  assign instruction = (pc < 32) ? mem[pc[4:0]] : 32'h0;

  // Program image: HALT at words 7 and 19, everything else tagged with its index.
  function automatic logic [31:0] word_at(input int i);
    if (i == 7 || i == 19) return 32'h0;
    return 32'h2000_0000 | (32'(i) << 16) | 32'(i);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"},       64'(pc),       64'h0);
    check({tag, "_valid"},    64'(if_valid), 64'h0);
    check({tag, "_instr"},    64'(if_instr), 64'h0);
    check({tag, "_if_pc"},    64'(if_pc),    64'h0);
    check({tag, "_halt"},     64'(if_halt),  64'h0);
    check({tag, "_halted"},   64'(halted),   64'h0);
  endtask

  task automatic do_start(input logic [31:0] spc);
    start    = 1'b1;
    start_pc = spc;
    tick();
    start    = 1'b0;
  endtask

  initial begin
    int nexp;
    int redirects;
    int cyc;
    bit done;
    bit rdy;
    bit redir;

    for (int i = 0; i < 32; i++) mem[i] = word_at(i);
    reset = 1'b1; start = 1'b0; start_pc = '0;
    redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check_reset_outputs("reset");

    // T1: sequential fetch 0..7 ending on HALT
    if_ready = 1'b1;
    do_start(32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("t1_valid_%0d", k), 64'(if_valid), 64'h1);
      check($sformatf("t1_pc_%0d", k),    64'(if_pc),    64'(k));
      check($sformatf("t1_instr_%0d", k), 64'(if_instr), 64'(word_at(k)));
    end
    check("t1_halt",   64'(if_halt), 64'h1);
    check("t1_halted", 64'(halted),  64'h1);
    check("t1_pcstay", 64'(pc),      64'd7);
    tick();
    check("t1_drain",  64'(if_valid), 64'h0);
    check("t1_pcstay2", 64'(pc),     64'd7);

    // T2: start at 8 through HALT at 19
    do_start(32'd8);
    for (int k = 8; k < 20; k++) begin
      tick();
      check($sformatf("t2_pc_%0d", k),    64'(if_pc),    64'(k));
      check($sformatf("t2_instr_%0d", k), 64'(if_instr), 64'(word_at(k)));
    end
    check("t2_first_word", 64'(word_at(8)), 64'h2008_0008);
    check("t2_halt",   64'(if_halt), 64'h1);
    check("t2_pc",     64'(pc),      64'd19);
    tick();

    // T3: backpressure after if_pc=2
    do_start(32'd0);
    tick(); tick(); tick();
    check("t3_pc2", 64'(if_pc), 64'd2);
    if_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("t3_hold_pc_%0d", k), 64'(if_pc),    64'd2);
      check($sformatf("t3_hold_v_%0d", k),  64'(if_valid), 64'h1);
      check($sformatf("t3_hold_fpc_%0d", k), 64'(pc),      64'd3);
    end
    if_ready = 1'b1;
    for (int k = 3; k < 8; k++) begin
      tick();
      check($sformatf("t3_seq_%0d", k), 64'(if_pc), 64'(k));
    end
    check("t3_halt", 64'(if_halt), 64'h1);
`ifdef FETCH_PERF_CNT_EN
    check("t6_fetch_count", 64'(fetch_count), 64'd8);
    check("t6_stall_count", 64'(stall_count), 64'd3);
`endif
    tick();

    // T4: redirect flushes the slot
    do_start(32'd8);
    tick(); tick();
    check("t4_pc9", 64'(if_pc), 64'd9);
    redirect_valid = 1'b1; redirect_pc = 32'd12; if_ready = 1'b0;
    tick();
    redirect_valid = 1'b0; if_ready = 1'b1;
    check("t4_flush", 64'(if_valid), 64'h0);
    check("t4_fpc",   64'(pc),       64'd12);
    tick();
    check("t4_v12",   64'(if_valid), 64'h1);
    check("t4_pc12",  64'(if_pc),    64'd12);
    tick();
    check("t4_pc13",  64'(if_pc),    64'd13);

    // T5: wrap past MEM_DEPTH-1, then reset mid-fetch
    do_start(32'd28);
    for (int k = 28; k < 32; k++) begin
      tick();
      check($sformatf("t5_pc_%0d", k), 64'(if_pc), 64'(k));
    end
    check("t5_wrap_pc", 64'(pc), 64'd0);
    tick();
    check("t5_wrap_if_pc", 64'(if_pc), 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_outputs("t5_reset");
    tick(); tick();
    check("t5_idle_v",  64'(if_valid), 64'h0);
    check("t5_idle_pc", 64'(pc),       64'h0);
    redirect_valid = 1'b1; redirect_pc = 32'd5;
    tick();
    redirect_valid = 1'b0;
    check("t5_idle_redir_pc", 64'(pc),       64'h0);
    check("t5_idle_redir_v",  64'(if_valid), 64'h0);

    // Randomized: consumed stream must follow the program order from each start/redirect target
    for (int it = 0; it < 12; it++) begin
      nexp = int'($urandom_range(0, 31));
      do_start(32'(nexp));
      done = 1'b0;
      redirects = 0;
      cyc = 0;
      while (!done && cyc < 400) begin
        rdy   = ($urandom_range(0, 3) != 0);
        redir = (redirects < 3) && ($urandom_range(0, 15) == 0);
        if (redir) begin
          redirects++;
          redirect_valid = 1'b1;
          redirect_pc    = 32'($urandom_range(0, 31));
          if_ready       = 1'b0;
          nexp           = int'(redirect_pc);
        end else begin
          if_ready = rdy;
          if (if_valid && rdy) begin
            check($sformatf("rnd%0d_pc", it),    64'(if_pc),    64'(nexp));
            check($sformatf("rnd%0d_instr", it), 64'(if_instr), 64'(word_at(nexp)));
            check($sformatf("rnd%0d_halt", it),  64'(if_halt),  64'(word_at(nexp) == 32'h0));
            if (word_at(nexp) == 32'h0) begin
              done = 1'b1;
              check($sformatf("rnd%0d_halted", it), 64'(halted), 64'h1);
              check($sformatf("rnd%0d_hpc", it),    64'(pc),     64'(nexp));
            end else begin
              nexp = (nexp + 1) % 32;
            end
          end
        end
        tick();
        redirect_valid = 1'b0;
        cyc++;
      end
      check($sformatf("rnd%0d_timeout", it), 64'(done), 64'h1);
      if_ready = 1'b1;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
